// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter
//   Shares one Wishbone master path to frame RAM between the video_in frame
//   writer (port 0) and the video_out frame reader (port 1). Whole bus cycles
//   are granted round-robin, with LOCK holding ownership across CYC gaps.
//   A per-access watchdog aborts a granted STB that waits TIMEOUT cycles
//   without ACK, so video_out cannot starve; each abort pulses timeout_irq
//   and records the aborted port in timeout_src.
//
// Ports
//   clk, RST            100 MHz clock, asynchronous active-high reset
//   m0_wb_*, m1_wb_*    requester slave ports (CYC/STB/LOCK/WE/SEL/ADR/DAT in, ACK out)
//   p_wb_*              shared master port toward the system interconnect
//   p_wb_DAT_I          RAM read data, fanned out to both requesters elsewhere
//   grant               registered one-hot owner (bit0 = port 0, bit1 = port 1)
//   timeout_irq         one-cycle pulse on a watchdog abort
//   timeout_src         sticky one-hot record of aborted ports, cleared by reset only
module wb_ram_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        m0_wb_CYC_I,
  input  logic        m0_wb_STB_I,
  input  logic        m0_wb_LOCK_I,
  input  logic        m0_wb_WE_I,
  input  logic [3:0]  m0_wb_SEL_I,
  input  logic [31:0] m0_wb_ADR_I,
  input  logic [31:0] m0_wb_DAT_I,
  output logic        m0_wb_ACK_O,
  input  logic        m1_wb_CYC_I,
  input  logic        m1_wb_STB_I,
  input  logic        m1_wb_LOCK_I,
  input  logic        m1_wb_WE_I,
  input  logic [3:0]  m1_wb_SEL_I,
  input  logic [31:0] m1_wb_ADR_I,
  input  logic [31:0] m1_wb_DAT_I,
  output logic        m1_wb_ACK_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I,
  input  logic [31:0] p_wb_DAT_I,
  output logic [1:0]  grant,
  output logic        timeout_irq,
  output logic [1:0]  timeout_src
);

  // One-hot encoding so the state register doubles as the grant output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state, next_state;
  logic            last_owner;
  logic [TO_W-1:0] wd;
  logic            own_cyc, own_stb, own_lock;
  logic            abort;

  // Read data is routed to the requesters outside this block.
  logic unused_rdata;
  assign unused_rdata = ^p_wb_DAT_I;

  assign grant = state;

  always_comb begin
    next_state  = state;
    own_cyc     = 1'b0;
    own_stb     = 1'b0;
    own_lock    = 1'b0;
    p_wb_CYC_O  = 1'b0;
    p_wb_STB_O  = 1'b0;
    p_wb_LOCK_O = 1'b0;
    p_wb_WE_O   = 1'b0;
    p_wb_SEL_O  = '0;
    p_wb_ADR_O  = '0;
    p_wb_DAT_O  = '0;
    m0_wb_ACK_O = 1'b0;
    m1_wb_ACK_O = 1'b0;

    case (state)
      OWN0: begin
        own_cyc     = m0_wb_CYC_I;
        own_stb     = m0_wb_STB_I;
        own_lock    = m0_wb_LOCK_I;
        p_wb_CYC_O  = m0_wb_CYC_I;
        p_wb_STB_O  = m0_wb_STB_I;
        p_wb_LOCK_O = m0_wb_LOCK_I;
        p_wb_WE_O   = m0_wb_WE_I;
        p_wb_SEL_O  = m0_wb_SEL_I;
        p_wb_ADR_O  = m0_wb_ADR_I;
        p_wb_DAT_O  = m0_wb_DAT_I;
        m0_wb_ACK_O = p_wb_ACK_I;
      end
      OWN1: begin
        own_cyc     = m1_wb_CYC_I;
        own_stb     = m1_wb_STB_I;
        own_lock    = m1_wb_LOCK_I;
        p_wb_CYC_O  = m1_wb_CYC_I;
        p_wb_STB_O  = m1_wb_STB_I;
        p_wb_LOCK_O = m1_wb_LOCK_I;
        p_wb_WE_O   = m1_wb_WE_I;
        p_wb_SEL_O  = m1_wb_SEL_I;
        p_wb_ADR_O  = m1_wb_ADR_I;
        p_wb_DAT_O  = m1_wb_DAT_I;
        m1_wb_ACK_O = p_wb_ACK_I;
      end
      default: ;
    endcase

    // ACK on the threshold cycle completes the access instead of aborting it.
    abort = (state != IDLE) && own_stb && !p_wb_ACK_I &&
            (wd == TO_W'(TIMEOUT - 1));

    case (state)
      IDLE: begin
        if (m0_wb_CYC_I && m1_wb_CYC_I)
          next_state = last_owner ? OWN0 : OWN1;
        else if (m0_wb_CYC_I)
          next_state = OWN0;
        else if (m1_wb_CYC_I)
          next_state = OWN1;
      end
      OWN0, OWN1: begin
        if (abort || (!own_cyc && !own_lock))
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      wd          <= '0;
      timeout_irq <= 1'b0;
      timeout_src <= '0;
    end else begin
      state       <= next_state;
      timeout_irq <= abort;

      if (state == IDLE || !own_stb || p_wb_ACK_I || abort)
        wd <= '0;
      else if (wd != TO_W'(TIMEOUT))
        wd <= wd + 1'b1;

      if (abort)
        timeout_src[state == OWN1] <= 1'b1;

      if (state != IDLE && next_state == IDLE)
        last_owner <= (state == OWN1);
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Randomized bench for wb_ram_arbiter with a cycle-level reference model of
// the sharing rules (owner index, round-robin, lock hold, watchdog abort).
module tb_wb_ram_arbiter;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TO_W    = 4;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        cyc [2], stb [2], lock [2], we [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2], dat [2];
  logic        ack_o [2];
  logic        p_cyc, p_stb, p_lock, p_we, p_ack;
  logic [3:0]  p_sel;
  logic [31:0] p_adr, p_dat, p_rdat;
  logic [1:0]  grant, timeout_src;
  logic        timeout_irq;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .RST(RST),
    .m0_wb_CYC_I(cyc[0]), .m0_wb_STB_I(stb[0]), .m0_wb_LOCK_I(lock[0]),
    .m0_wb_WE_I(we[0]), .m0_wb_SEL_I(sel[0]), .m0_wb_ADR_I(adr[0]),
    .m0_wb_DAT_I(dat[0]), .m0_wb_ACK_O(ack_o[0]),
    .m1_wb_CYC_I(cyc[1]), .m1_wb_STB_I(stb[1]), .m1_wb_LOCK_I(lock[1]),
    .m1_wb_WE_I(we[1]), .m1_wb_SEL_I(sel[1]), .m1_wb_ADR_I(adr[1]),
    .m1_wb_DAT_I(dat[1]), .m1_wb_ACK_O(ack_o[1]),
    .p_wb_CYC_O(p_cyc), .p_wb_STB_O(p_stb), .p_wb_LOCK_O(p_lock),
    .p_wb_WE_O(p_we), .p_wb_SEL_O(p_sel), .p_wb_ADR_O(p_adr),
    .p_wb_DAT_O(p_dat), .p_wb_ACK_I(p_ack), .p_wb_DAT_I(p_rdat),
    .grant(grant), .timeout_irq(timeout_irq), .timeout_src(timeout_src)
  );

  // Reference model: owner is -1 when the bus is idle, else the port index.
  int          m_owner, m_last, m_wait;
  logic        m_irq;
  logic [1:0]  m_src;
  int unsigned n_abort, n_grant [2];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_wait = 0; m_irq = 1'b0; m_src = 2'b00;
  endtask

  task automatic check_outputs();
    logic [71:0] bus_exp;
    logic [1:0]  g_exp;
    logic        a_exp [2];
    bus_exp = '0; g_exp = 2'b00; a_exp[0] = 1'b0; a_exp[1] = 1'b0;
    if (m_owner >= 0) begin
      bus_exp = {cyc[m_owner], stb[m_owner], lock[m_owner], we[m_owner],
                 sel[m_owner], adr[m_owner], dat[m_owner]};
      g_exp[m_owner] = 1'b1;
      a_exp[m_owner] = p_ack;
    end
    check("bus", {p_cyc, p_stb, p_lock, p_we, p_sel, p_adr, p_dat}, bus_exp);
    check("grant", 72'(grant), 72'(g_exp));
    check("ack", {70'd0, ack_o[1], ack_o[0]}, {70'd0, a_exp[1], a_exp[0]});
    check("irq", 72'(timeout_irq), 72'(m_irq));
    check("src", 72'(timeout_src), 72'(m_src));
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit aborted;
    aborted = 0;
    m_irq = 1'b0;
    if (m_owner < 0) begin
      m_wait = 0;
      if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
      else if (cyc[0])      m_owner = 0;
      else if (cyc[1])      m_owner = 1;
      if (m_owner >= 0) n_grant[m_owner]++;
    end else begin
      if (!stb[m_owner] || p_ack) m_wait = 0;
      else if (m_wait == int'(TIMEOUT) - 1) aborted = 1;
      else m_wait++;
      if (aborted) begin
        m_irq = 1'b1;
        m_src[m_owner] = 1'b1;
        m_last = m_owner; m_owner = -1; m_wait = 0;
        n_abort++;
      end else if (!cyc[m_owner] && !lock[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end
    end
  endtask

  task automatic rand_payload(input int p);
    we[p]  = 1'($urandom);
    sel[p] = 4'($urandom);
    adr[p] = $urandom;
    dat[p] = $urandom;
  endtask

  initial begin
    n_abort = 0; n_grant[0] = 0; n_grant[1] = 0;
    for (int p = 0; p < 2; p++) begin
      cyc[p] = 1'b1; stb[p] = 1'b1; lock[p] = 1'b1;
      rand_payload(p);
    end
    p_ack = 1'b1; p_rdat = 32'h1234_5678;
    model_reset();

    // Requests asserted during reset must not reach the bus.
    #12;
    check_outputs();
    check("reset_cyc", 72'(p_cyc), 72'd0);

    @(negedge clk);
    RST = 1'b0;
    for (int p = 0; p < 2; p++) begin cyc[p] = 1'b0; stb[p] = 1'b0; lock[p] = 1'b0; end
    p_ack = 1'b0;

    // Simultaneous first request goes to port 0 (last owner is 1 out of reset).
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    @(posedge clk); model_step();
    #1 check("first_grant", 72'(grant), 72'd1);

    for (int c = 0; c < 3000; c++) begin
      int ack_pct;
      @(negedge clk);
      // Alternate quiet-RAM and responsive-RAM stretches so the watchdog fires.
      ack_pct = ((c / 60) % 3 == 0) ? 0 : 35;
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 5) == 0) cyc[p] = ~cyc[p];
        stb[p]  = cyc[p] && ($urandom_range(0, 3) != 0);
        lock[p] = ($urandom_range(0, 4) == 0);
        rand_payload(p);
      end
      p_ack = (int'($urandom_range(0, 99)) < ack_pct);
      p_rdat = $urandom;
      #1 check_outputs();
      @(posedge clk);
      model_step();
    end

    // Asynchronous reset while port 0 owns the bus with STB high.
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin cyc[p] = 1'b0; stb[p] = 1'b0; lock[p] = 1'b0; end
    p_ack = 1'b0;
    @(posedge clk); model_step();
    @(negedge clk);
    @(posedge clk); model_step();
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); model_step();
    #2 check("pre_rst_grant", 72'(grant), 72'd1);
    check("pre_rst_stb", 72'(p_stb), 72'd1);
    #1 RST = 1'b1; p_ack = 1'b1;
    model_reset();
    #1;
    check("rst_cyc", 72'(p_cyc), 72'd0);
    check("rst_stb", 72'(p_stb), 72'd0);
    check("rst_grant", 72'(grant), 72'd0);
    check("rst_src", 72'(timeout_src), 72'd0);
    check("rst_ack", 72'(ack_o[0]), 72'd0);
    check_outputs();

    check("saw_abort", 72'(n_abort > 0), 72'd1);
    check("saw_both_grants", 72'(n_grant[0] > 0 && n_grant[1] > 0), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
